ztex_hostif_multi: RTL and testbench

Parametrised host-interface block between the EZ-USB byte port and one or more hash pipes.
- Input side: synchronises host strobes and assembles a work frame (midstate + data). It commits the frame atomically, so the hash pipes never see a partially shifted word.
- Output side: snapshots results from NUM_CORES pipes and serialises them byte-wise to the host.
- Successor to the single-pipe shift buffer: adds core count, frame counting, atomic commit and configurable synchroniser depth.

---
 rtl/ztex_hostif_pkg.sv | 31 +++
 rtl/ztex_sync_edge.sv | 29 ++
 rtl/ztex_hostif_multi.sv | 155 +++++++++++++++
 tb/tb_ztex_hostif_multi.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ztex_hostif_pkg.sv
// rtl/ztex_hostif_pkg.sv - shared constants and helpers for the multi-core host interface
//
// Purpose: byte/word geometry of the result frame and the XOR checksum
// helper used when HOSTIF_CHECKSUM_EN is defined.
// Ports: none (package).
package ztex_hostif_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_CORE = 3;
  localparam int BYTES_PER_CORE = WORDS_PER_CORE * WORD_W / BYTE_W;

  // Upper bound on the payload the checksum helper can fold; callers
  // zero-extend their payload, and zero bytes do not change an XOR.
  localparam int MAX_IN_BYTES   = 128;

  // Length of the serialised result frame for a given core count.
  function automatic int out_bytes(input int num_cores);
    return num_cores * BYTES_PER_CORE;
  endfunction

  function automatic logic [BYTE_W-1:0] xor_bytes(input logic [MAX_IN_BYTES*BYTE_W-1:0] v);
    logic [BYTE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_IN_BYTES; i++) begin
      acc = acc ^ v[i*BYTE_W +: BYTE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/ztex_sync_edge.sv
// rtl/ztex_sync_edge.sv - multi-flop synchroniser with toggle and rise event outputs
//
// Purpose: brings one asynchronous host strobe onto clk and flags changes.
// Ports:
//   clk, reset (async, active-low)
//   async_in   asynchronous host level/strobe
//   toggle     one-cycle event: last two stages differ
//   rise       one-cycle event: synced level went 0 -> 1
module ztex_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic toggle,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], async_in};
  end

  assign toggle = chain[SYNC_STAGES-1] ^ chain[SYNC_STAGES-2];
  assign rise   = chain[SYNC_STAGES-2] & ~chain[SYNC_STAGES-1];

endmodule

// File: rtl/ztex_hostif_multi.sv
// rtl/ztex_hostif_multi.sv - EZ-USB byte port to multi-core hash pipe host interface
//
// Purpose: assembles host bytes into a work frame committed atomically, and
// serialises per-core result snapshots back to the host byte by byte.
// Optional build macro: HOSTIF_CHECKSUM_EN (trailing XOR byte, chk_err port).
// Ports:
//   clk, reset (async, active-low)
//   rd_clk    host write strobe, each toggle delivers the byte on read
//   wr_clk    host read strobe, each toggle advances write by one byte
//   wr_start  host snapshot request (rising level)
//   read      host data byte in; write  output byte to host
//   golden_nonce/nonce2/hash2  per-core 32-bit results, core 0 in [31:0]
//   work_data committed frame, first byte in [7:0]; work_valid commit pulse
//   frame_cnt committed frame count (wraps); chk_err sticky checksum error
module ztex_hostif_multi
  import ztex_hostif_pkg::*;
#(
  parameter int IN_BYTES    = 44,
  parameter int NUM_CORES   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_clk,
  input  logic                     wr_clk,
  input  logic                     wr_start,
  input  logic [7:0]               read,
  output logic [7:0]               write,
  input  logic [32*NUM_CORES-1:0]  golden_nonce,
  input  logic [32*NUM_CORES-1:0]  nonce2,
  input  logic [32*NUM_CORES-1:0]  hash2,
  output logic [8*IN_BYTES-1:0]    work_data,
  output logic                     work_valid,
  output logic [7:0]               frame_cnt
`ifdef HOSTIF_CHECKSUM_EN
  ,
  output logic                     chk_err
`endif
);

`ifdef HOSTIF_CHECKSUM_EN
  localparam int FRAME_BYTES = IN_BYTES + 1;
`else
  localparam int FRAME_BYTES = IN_BYTES;
`endif
  localparam int OUT_BYTES = out_bytes(NUM_CORES);
  localparam int IN_CNT_W  = $clog2(FRAME_BYTES);
  localparam int OUT_IDX_W = $clog2(OUT_BYTES + 1);
  localparam logic [IN_CNT_W-1:0]  LAST_IN = IN_CNT_W'(FRAME_BYTES - 1);
  localparam logic [OUT_IDX_W-1:0] OUT_END = OUT_IDX_W'(OUT_BYTES);

  logic rd_ev, wr_ev, snap_ev;
  logic rd_rise_unused, wr_rise_unused, snap_tog_unused;

  ztex_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .reset(reset), .async_in(rd_clk), .toggle(rd_ev), .rise(rd_rise_unused));
  ztex_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .reset(reset), .async_in(wr_clk), .toggle(wr_ev), .rise(wr_rise_unused));
  ztex_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_snap (
    .clk(clk), .reset(reset), .async_in(wr_start), .toggle(snap_tog_unused), .rise(snap_ev));

  // ---------------- input assembly ----------------
  logic [7:0]          stage_mem [IN_BYTES];
  logic [IN_CNT_W-1:0] in_cnt;
  logic [IN_CNT_W-1:0] in_idx;

  // A snapshot in the same cycle restarts the frame before the byte lands.
  assign in_idx = snap_ev ? '0 : in_cnt;

`ifdef HOSTIF_CHECKSUM_EN
  logic [MAX_IN_BYTES*BYTE_W-1:0] chk_vec;
  logic                           chk_ok;
  always_comb begin
    chk_vec = '0;
    for (int i = 0; i < IN_BYTES; i++) chk_vec[8*i +: 8] = stage_mem[i];
  end
  assign chk_ok = (xor_bytes(chk_vec) == read);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt     <= '0;
      work_data  <= '0;
      work_valid <= 1'b0;
      frame_cnt  <= '0;
      for (int i = 0; i < IN_BYTES; i++) stage_mem[i] <= '0;
`ifdef HOSTIF_CHECKSUM_EN
      chk_err    <= 1'b0;
`endif
    end else begin
      work_valid <= 1'b0;
      if (snap_ev) in_cnt <= '0;
      if (rd_ev) begin
        if (in_idx == LAST_IN) begin
          in_cnt <= '0;
`ifdef HOSTIF_CHECKSUM_EN
          // Final byte is the checksum; the payload is entirely in staging.
          if (chk_ok) begin
            for (int i = 0; i < IN_BYTES; i++) work_data[8*i +: 8] <= stage_mem[i];
            work_valid <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            chk_err    <= 1'b0;
          end else begin
            chk_err    <= 1'b1;
          end
`else
          // Final payload byte goes straight into work_data with the rest.
          for (int i = 0; i < IN_BYTES - 1; i++) work_data[8*i +: 8] <= stage_mem[i];
          work_data[8*(IN_BYTES-1) +: 8] <= read;
          work_valid <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
`endif
        end else begin
          stage_mem[in_idx] <= read;
          in_cnt            <= in_idx + 1'b1;
        end
      end
    end
  end

  // ---------------- output snapshot / shift ----------------
  logic [7:0]           snap_frame [OUT_BYTES];
  logic [7:0]           out_mem    [OUT_BYTES];
  logic [OUT_IDX_W-1:0] out_idx;
  logic [OUT_IDX_W-1:0] out_next;

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int b = 0; b < 4; b++) begin
        snap_frame[c*BYTES_PER_CORE + b]     = golden_nonce[32*c + 8*b +: 8];
        snap_frame[c*BYTES_PER_CORE + 4 + b] = nonce2[32*c + 8*b +: 8];
        snap_frame[c*BYTES_PER_CORE + 8 + b] = hash2[32*c + 8*b +: 8];
      end
    end
  end

  // Index saturates one past the last byte; write then reads as zero.
  assign out_next = (out_idx == OUT_END) ? out_idx : out_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_idx <= '0;
      write   <= 8'h00;
      for (int i = 0; i < OUT_BYTES; i++) out_mem[i] <= '0;
    end else if (snap_ev) begin
      out_mem <= snap_frame;
      out_idx <= '0;
      write   <= snap_frame[0];
    end else if (wr_ev) begin
      out_idx <= out_next;
      write   <= (out_next == OUT_END) ? 8'h00 : out_mem[out_next];
    end
  end

endmodule

// File: tb/tb_ztex_hostif_multi.sv
// tb/tb_ztex_hostif_multi.sv - self-checking bench for ztex_hostif_multi
module tb_ztex_hostif_multi;

  localparam int IN_BYTES  = 44;
  localparam int NUM_CORES = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rd_clk = 1'b0, wr_clk = 1'b0, wr_start = 1'b0;
  logic [7:0] read = 8'h00;
  logic [7:0] write;
  logic [32*NUM_CORES-1:0] golden_nonce, nonce2, hash2;
  logic [8*IN_BYTES-1:0] work_data;
  logic work_valid;
  logic [7:0] frame_cnt;
`ifdef HOSTIF_CHECKSUM_EN
  logic chk_err;
`endif

  ztex_hostif_multi #(.IN_BYTES(IN_BYTES), .NUM_CORES(NUM_CORES), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rd_clk(rd_clk), .wr_clk(wr_clk), .wr_start(wr_start),
    .read(read), .write(write), .golden_nonce(golden_nonce), .nonce2(nonce2), .hash2(hash2),
    .work_data(work_data), .work_valid(work_valid), .frame_cnt(frame_cnt)
`ifdef HOSTIF_CHECKSUM_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*IN_BYTES-1:0] data;
    logic [7:0]            cnt;
  } commit_t;

  typedef struct {
    bit         snap;
    bit         toggle;
    logic [7:0] exp;
  } vec_t;

  commit_t    exp_q[$];
  vec_t       vt[26];
  logic [7:0] fb[IN_BYTES];
  logic [7:0] exp_cnt = 8'd0;
  int vectors = 0;
  int miscompares = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every commit pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (reset && work_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_commit: work_valid=1 frame_cnt=%0d, expected no commit", frame_cnt);
      end else begin
        commit_t e;
        e = exp_q.pop_front();
        if (work_data !== e.data || frame_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL commit: work_data=%h cnt=%0d, expected %h cnt=%0d",
                   work_data, frame_cnt, e.data, e.cnt);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    read   = b;
    rd_clk = ~rd_clk;
    wait_cycles(6);
  endtask

  task automatic push_expected();
    commit_t e;
    for (int i = 0; i < IN_BYTES; i++) e.data[8*i +: 8] = fb[i];
    exp_cnt = exp_cnt + 8'd1;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Sends fb; the expectation is queued before the byte that completes the frame.
  task automatic send_buf(input bit push, input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < IN_BYTES; i++) begin
      x = x ^ fb[i];
`ifndef HOSTIF_CHECKSUM_EN
      if (i == IN_BYTES - 1 && push) push_expected();
`endif
      send_byte(fb[i]);
    end
`ifdef HOSTIF_CHECKSUM_EN
    if (push && !corrupt) push_expected();
    send_byte(corrupt ? ~x : x);
`else
    if (corrupt) x = 8'h00;
`endif
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d commits outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic toggle_wr();
    @(negedge clk);
    wr_clk = ~wr_clk;
    wait_cycles(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[6];
    w[0] = 32'h11223344; w[1] = 32'h55667788; w[2] = 32'h99AABBCC;
    w[3] = 32'hDEADBEEF; w[4] = 32'hDEADBEEF; w[5] = 32'hDEADBEEF;
    for (int i = 0; i < 26; i++) begin
      logic [31:0] wd;
      vt[i].snap   = (i == 0);
      vt[i].toggle = (i != 0);
      if (i < 24) begin
        wd = w[i/4];
        vt[i].exp = wd[8*(i%4) +: 8];
      end else begin
        vt[i].exp = 8'h00;
      end
    end
    golden_nonce = {w[3], w[0]};
    nonce2       = {w[4], w[1]};
    hash2        = {w[5], w[2]};

    // Reset state
    wait_cycles(4);
    check8("rst_work_data_lo", work_data[7:0], 8'h00);
    vectors++;
    if (work_data !== '0) begin
      miscompares++;
      $display("FAIL rst_work_data: got %h expected 0", work_data);
    end
    check8("rst_work_valid", {7'd0, work_valid}, 8'h00);
    check8("rst_write", write, 8'h00);
    check8("rst_frame_cnt", frame_cnt, 8'h00);
`ifdef HOSTIF_CHECKSUM_EN
    check8("rst_chk_err", {7'd0, chk_err}, 8'h00);
`endif
    reset = 1'b1;
    wait_cycles(4);

    // Frame of bytes 0x00..0x2B
    for (int i = 0; i < IN_BYTES; i++) fb[i] = 8'(i);
    send_buf(1'b1, 1'b0);
    drain("frame_ramp");
    check8("frame_ramp_cnt", frame_cnt, 8'd1);

    // Snapshot + byte serialisation, table-driven
    for (int i = 0; i < 26; i++) begin
      if (vt[i].snap) begin
        @(negedge clk);
        wr_start = 1'b1;
        wait_cycles(6);
      end
      if (vt[i].toggle) toggle_wr();
      check8($sformatf("shift_%0d", i), write, vt[i].exp);
    end
    @(negedge clk);
    wr_start = 1'b0;
    wait_cycles(6);

    // Partial frame aborted by a snapshot, then a full 0xA5 frame
    for (int i = 0; i < 20; i++) send_byte(8'(i + 8'h60));
    @(negedge clk);
    wr_start = 1'b1;
    wait_cycles(6);
    for (int i = 0; i < IN_BYTES; i++) fb[i] = 8'hA5;
    send_buf(1'b1, 1'b0);
    drain("frame_abort");
    @(negedge clk);
    wr_start = 1'b0;
    wait_cycles(6);

    // Snapshot and wr toggle arriving in the same cycle
    toggle_wr();
    toggle_wr();
    toggle_wr();
    check8("pre_simul_idx3", write, 8'h11);
    @(negedge clk);
    wr_start = 1'b1;
    wr_clk   = ~wr_clk;
    wait_cycles(6);
    check8("simul_snap_wins", write, 8'h44);
    toggle_wr();
    check8("simul_wr_dropped", write, 8'h33);
    @(negedge clk);
    wr_start = 1'b0;
    wait_cycles(6);

    // Reset in the middle of a frame
    for (int i = 0; i < 30; i++) send_byte(8'(i + 8'h40));
    @(negedge clk);
    reset    = 1'b0;
    rd_clk   = 1'b0;
    wr_clk   = 1'b0;
    wr_start = 1'b0;
    wait_cycles(3);
    check8("midrst_frame_cnt", frame_cnt, 8'h00);
    check8("midrst_write", write, 8'h00);
    exp_cnt = 8'd0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(4);
    for (int i = 0; i < IN_BYTES; i++) fb[i] = 8'(i + 8'h80);
    send_buf(1'b1, 1'b0);
    drain("frame_after_reset");
    check8("after_reset_cnt", frame_cnt, 8'd1);

`ifdef HOSTIF_CHECKSUM_EN
    for (int i = 0; i < IN_BYTES; i++) fb[i] = 8'(3 * i + 8'h07);
    send_buf(1'b1, 1'b1);
    check8("bad_chk_err", {7'd0, chk_err}, 8'h01);
    check8("bad_chk_cnt", frame_cnt, 8'd1);
    send_buf(1'b1, 1'b0);
    drain("good_chk_frame");
    check8("good_chk_err", {7'd0, chk_err}, 8'h00);
    check8("good_chk_cnt", frame_cnt, 8'd2);
`endif

    wait_cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
